// File: rtl/silife_pkg.sv
// Shared types and default sizes for the Game of Life cell array.
package silife_pkg;

  localparam int unsigned SILIFE_ROWS = 8;
  localparam int unsigned SILIFE_COLS = 8;

  typedef logic [SILIFE_ROWS-1:0][SILIFE_COLS-1:0] cell_grid_t;
  typedef logic [3:0]                              nbr_count_t;

endpackage

// File: rtl/silife_cell.sv
// One Game of Life cell: neighbour popcount, life rule and the state flop.
module silife_cell
  import silife_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic       set,
  input  logic [7:0] nbrs,
  output logic       alive
);

  nbr_count_t count;
  logic       alive_d;
  logic       alive_q;

  // Count live neighbours and apply the rule; set only ever forces alive.
  always_comb begin
    count = '0;
    for (int i = 0; i < 8; i++) begin
      count = count + nbr_count_t'(nbrs[i]);
    end
    if (enable) begin
      alive_d = (count == 4'd3) | (alive_q & (count == 4'd2)) | set;
    end else begin
      alive_d = alive_q | set;
    end
  end

  // Cell state; asynchronous reset clears it immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alive_q <= 1'b0;
    end else begin
      alive_q <= alive_d;
    end
  end

  assign alive = alive_q;

endmodule

// File: rtl/silife_grid8x8.sv
// Game of Life cell array: wires each cell to its 8 neighbours.
// Define SILIFE_WRAP_EN for a toroidal grid; otherwise off-grid neighbours read as dead.
module silife_grid8x8
  import silife_pkg::*;
#(
  parameter int unsigned ROWS = SILIFE_ROWS,
  parameter int unsigned COLS = SILIFE_COLS
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      enable,
  input  logic [ROWS-1:0][COLS-1:0] set_cells,
  output logic [ROWS-1:0][COLS-1:0] cells
);

  for (genvar r = 0; r < int'(ROWS); r++) begin : g_row
    for (genvar c = 0; c < int'(COLS); c++) begin : g_col
      logic [7:0] nbrs;

      // Neighbour k: rows above (k=0..2), same row (k=3,4), below (k=5..7).
      for (genvar k = 0; k < 8; k++) begin : g_nbr
        localparam int DR = (k < 3) ? -1 : ((k < 5) ? 0 : 1);
        localparam int DC = (k == 0 || k == 3 || k == 5) ? -1 :
                            ((k == 1 || k == 6) ? 0 : 1);
        localparam int RN = r + DR;
        localparam int CN = c + DC;
`ifdef SILIFE_WRAP_EN
        localparam int RW = (RN + int'(ROWS)) % int'(ROWS);
        localparam int CW = (CN + int'(COLS)) % int'(COLS);
        assign nbrs[k] = cells[RW][CW];
`else
        if (RN >= 0 && RN < int'(ROWS) && CN >= 0 && CN < int'(COLS)) begin : g_in
          assign nbrs[k] = cells[RN][CN];
        end else begin : g_off
          assign nbrs[k] = 1'b0;
        end
`endif
      end

      silife_cell u_cell (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .set    (set_cells[r][c]),
        .nbrs   (nbrs),
        .alive  (cells[r][c])
      );
    end
  end

endmodule

// File: tb/tb_silife_grid8x8.sv
// Directed and random checks of silife_grid8x8 against a behavioural Life model.
module tb_silife_grid8x8;
  import silife_pkg::*;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       enable = 1'b0;
  cell_grid_t set_cells = '0;
  cell_grid_t cells;

  int vectors = 0;
  int miscompares = 0;
  cell_grid_t mdl = '0;

  silife_grid8x8 dut (
    .clk       (clk),
    .reset     (reset),
    .enable    (enable),
    .set_cells (set_cells),
    .cells     (cells)
  );

  always #5 clk = ~clk;

  // One generation of Conway's Life computed straight from the rules.
  function automatic cell_grid_t life(input cell_grid_t g);
    cell_grid_t nx = '0;
    for (int r = 0; r < 8; r++) begin
      for (int c = 0; c < 8; c++) begin
        int n = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            int rr = r + dr;
            int cc = c + dc;
            if (dr == 0 && dc == 0) continue;
`ifdef SILIFE_WRAP_EN
            rr = (rr + 8) % 8;
            cc = (cc + 8) % 8;
`else
            if (rr < 0 || rr > 7 || cc < 0 || cc > 7) continue;
`endif
            n += int'(g[rr][cc]);
          end
        end
        nx[r][c] = (n == 3) || (g[r][c] && n == 2);
      end
    end
    return nx;
  endfunction

  task automatic chk(input string tag, input cell_grid_t exp);
    vectors++;
    assert (cells === exp) else begin
      miscompares++;
      $error("FAIL %s: cells=%h expected=%h", tag, cells, exp);
    end
  endtask

  // Apply one clock edge with the given controls and compare against the model.
  task automatic step(input logic en, input cell_grid_t set, input string tag);
    cell_grid_t exp;
    @(negedge clk);
    enable    = en;
    set_cells = set;
    exp = en ? (life(mdl) | set) : (mdl | set);
    @(posedge clk);
    #1;
    mdl = exp;
    chk(tag, exp);
  endtask

  // Pulse reset away from clock edges; cells must clear without an edge.
  task automatic do_reset(input string tag);
    @(negedge clk);
    enable    = 1'b0;
    set_cells = '0;
    #2;
    reset = 1'b1;
    #1;
    chk(tag, '0);
    reset = 1'b0;
    mdl = '0;
  endtask

  cell_grid_t g;
  cell_grid_t blink_h;
  cell_grid_t blink_v;
  cell_grid_t glider;
  cell_grid_t ring;

  initial begin
    // Reset held across an edge with set_cells active: stays clear.
    @(negedge clk);
    enable    = 1'b1;
    set_cells = '1;
    @(posedge clk);
    #1;
    chk("reset_held", '0);
    @(negedge clk);
    enable    = 1'b0;
    set_cells = '0;
    reset     = 1'b0;

    // Blinker load and oscillation.
    blink_h = '0; blink_h[4][4] = 1'b1; blink_h[4][5] = 1'b1; blink_h[4][6] = 1'b1;
    blink_v = '0; blink_v[3][5] = 1'b1; blink_v[4][5] = 1'b1; blink_v[5][5] = 1'b1;
    step(1'b1, blink_h, "blinker_load");
    chk("blinker_load_const", blink_h);
    step(1'b1, '0, "blinker_gen1");
    chk("blinker_gen1_const", blink_v);
    step(1'b1, '0, "blinker_gen2");
    chk("blinker_gen2_const", blink_h);

    // Asynchronous reset mid-cycle with a live pattern.
    do_reset("reset_async");

    // Block still life over 5 generations.
    g = '0; g[2][2] = 1'b1; g[2][3] = 1'b1; g[3][2] = 1'b1; g[3][3] = 1'b1;
    step(1'b0, g, "block_load");
    for (int i = 0; i < 5; i++) begin
      step(1'b1, '0, "block_gen");
      chk("block_const", g);
    end
    do_reset("reset_block");

    // Hold with a glider; then a single forced cell.
    glider = '0;
    glider[1][2] = 1'b1; glider[2][3] = 1'b1;
    glider[3][1] = 1'b1; glider[3][2] = 1'b1; glider[3][3] = 1'b1;
    step(1'b0, glider, "glider_load");
    for (int i = 0; i < 4; i++) begin
      step(1'b0, '0, "hold");
      chk("hold_const", glider);
    end
    g = '0; g[0][0] = 1'b1;
    step(1'b0, g, "hold_set");
    g = g | glider;
    chk("hold_set_const", g);
    for (int i = 0; i < 4; i++) step(1'b1, '0, "glider_run");
    do_reset("reset_glider");

    // Corner L becomes a block.
    g = '0; g[0][0] = 1'b1; g[0][1] = 1'b1; g[1][0] = 1'b1;
    step(1'b0, g, "corner_load");
    step(1'b1, '0, "corner_gen");
    g[1][1] = 1'b1;
    chk("corner_const", g);
    do_reset("reset_corner");

    // Blinker on the top edge.
    g = '0; g[0][3] = 1'b1; g[0][4] = 1'b1; g[0][5] = 1'b1;
    step(1'b0, g, "edge_load");
    step(1'b1, '0, "edge_gen");
    g = '0; g[0][4] = 1'b1; g[1][4] = 1'b1;
`ifdef SILIFE_WRAP_EN
    g[7][4] = 1'b1;
`endif
    chk("edge_const", g);
    do_reset("reset_edge");

    // Overcrowding kills the centre; a simultaneous set keeps it alive.
    ring = '0;
    for (int r = 3; r <= 5; r++) for (int c = 3; c <= 5; c++) ring[r][c] = 1'b1;
    step(1'b0, ring, "crowd_load");
    step(1'b1, '0, "crowd_gen");
    vectors++;
    assert (cells[4][4] === 1'b0) else begin
      miscompares++;
      $error("FAIL crowd_centre: cells[4][4]=%b expected=0", cells[4][4]);
    end
    do_reset("reset_crowd");
    step(1'b0, ring, "crowd_load2");
    g = '0; g[4][4] = 1'b1;
    step(1'b1, g, "crowd_set");
    vectors++;
    assert (cells[4][4] === 1'b1) else begin
      miscompares++;
      $error("FAIL crowd_set_centre: cells[4][4]=%b expected=1", cells[4][4]);
    end

    // Random soup: mixed enable and sparse set masks.
    do_reset("reset_random");
    for (int i = 0; i < 60; i++) begin
      cell_grid_t s;
      s = {$urandom, $urandom} & {$urandom, $urandom} & {$urandom, $urandom};
      if (i % 10 == 0) s = {$urandom, $urandom};
      step(1'(($urandom % 4) != 0), s, "random");
    end
    do_reset("reset_final");

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/silife_grid8x8.md
Name: silife_grid8x8

Overview:
- Synchronous 8x8 Conway's Game of Life cell array.
- Each rising clock edge, when enabled, computes one generation for all cells in parallel.
- Host can force individual cells alive through a per-cell set mask.
- Sits between the controller (load/step control) and the display/readout logic, which consumes the cell state.

Parameters:
- ROWS, 8, number of rows in the grid.
- COLS, 8, number of columns in the grid.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all cells.
- enable  input  1  when high, advance one generation per clock.
- set_cells  input  ROWS x COLS (packed [ROWS-1:0][COLS-1:0])  per-cell force-alive mask; bit [r][c] addresses row r, column c.
- cells  output  ROWS x COLS (packed [ROWS-1:0][COLS-1:0])  current cell state, 1 = alive; driven directly from registers.

Behaviour:
- State: one flop per cell, ROWS*COLS flops total. cells[r][c] is the flop output, with no combinational path from inputs.
- Reset: asserting reset clears every cell to 0 immediately, regardless of clk. While reset is held, cells stays all-zero and set_cells is ignored.
- Neighbour count n(r,c): number of live cells among the 8 surrounding positions.
  - Positions outside the grid count as dead (no wrap), unless the wrap feature is enabled.
  - Count width is 4 bits, range 0..8.
- Life rule: next(r,c) = (n == 3) | (cells[r][c] & n == 2).
- Per rising edge, each cell updates to:
  - enable=1: next(r,c) | set_cells[r][c]
  - enable=0: cells[r][c] | set_cells[r][c]
- Consequences:
  - set_cells only sets and never clears.
  - A set bit forces the cell alive on that edge even if the rule would kill it.
  - set_cells does not affect neighbour counts in the same cycle. Counts always use the registered state.
- Latency: one clock from enable/set_cells to the updated cells.
- Simultaneous load and step: the generation is computed from the old state, then the set mask is ORed in.
- Reset release: the first rising edge after reset deassertion performs a normal update.
- Reset mid-operation: the pattern is lost and all cells read 0.

Optional Feature:
- Macro: SILIFE_WRAP_EN.
- Defined: toroidal grid.
  - Row index wraps modulo ROWS, so row -1 is row ROWS-1.
  - Column index wraps modulo COLS.
  - Corner cells have neighbours at the opposite corners.
- Undefined (default): off-grid neighbours are constant 0.

Decomposition:
- Package silife_pkg:
  - localparams SILIFE_ROWS=8 and SILIFE_COLS=8.
  - typedef cell_grid_t = logic [ROWS-1:0][COLS-1:0].
  - typedef nbr_count_t = logic [3:0].
- Sub-module silife_cell, instantiated ROWS*COLS times via generate. It contains:
  - inputs: clk, reset, enable, set, 8-bit neighbour vector;
  - output: alive;
  - a popcount, the life rule, and the flop.
- Top level handles only neighbour wiring, including edge/wrap handling.

Test Plan:
- Reset: assert reset asynchronously mid-cycle with cells non-zero -> cells == 0 immediately, without waiting for a clk edge.
- Blinker load and step (enable=1):
  - Release reset; present set_cells = {[4][4],[4][5],[4][6]} for one edge -> cells holds exactly those 3 bits.
  - Clear set_cells; next edge -> exactly [3][5],[4][5],[5][5].
  - Next edge -> back to row 4, cols 4..6.
- Block still life: load [2][2],[2][3],[3][2],[3][3] -> unchanged over 5 generations.
- Hold: enable=0 with a glider loaded -> cells unchanged across 4 edges. Asserting set_cells[0][0] on one edge adds only that cell.
- Edge/corner:
  - Load [0][0],[0][1],[1][0] -> next generation adds [1][1], giving the 4-cell block.
  - Load a horizontal blinker at [0][3..5] -> next generation is [0][4],[1][4]: the row above is off-grid and counts dead.
  - With SILIFE_WRAP_EN, the same blinker instead gives [7][4],[0][4],[1][4].
- Overcrowding and simultaneous set:
  - Center cell [4][4] alive with all 8 neighbours alive -> [4][4] dies.
  - Same pattern with set_cells[4][4]=1 on that edge -> [4][4] stays 1.
